// File: rtl/dmem_bridge.sv
// dmem_bridge: converts a memory-stage load/store into a valid/ready bus request.
// It stalls the pipeline until the response arrives, or until the wait timeout
// expires, in which case it returns zero data and pulses errM.
//
// state  | meaning
// IDLE   | no access in flight; a new request is captured here
// REQ    | req_valid held high until req_ready completes the handshake
// WAIT   | waiting for rsp_valid, bounded by the TIMEOUT wait counter
// DONE   | one-cycle completion; rdataM valid, stall released
module dmem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        weM,
  input  logic        reM,
  input  logic [3:0]  ampM,
  output logic [31:0] rdataM,
  output logic        stallM,
  output logic        errM,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic        req_we,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [7:0]  r_wcnt;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_valid;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic        w_req;
  logic        w_err;
  logic        w_go;
  logic [2:0]  w_ones;
  logic [31:0] w_wdata;
  logic        w_timeout;

  // A store with no byte lanes enabled is rejected before it reaches the bus.
  assign w_req  = reM | weM;
  assign w_err  = weM & (ampM == 4'b0000);
  assign w_go   = w_req & ~w_err;
  assign w_ones = {2'b00, ampM[0]} + {2'b00, ampM[1]} + {2'b00, ampM[2]} + {2'b00, ampM[3]};

  // Replicate narrow store data across the word so any enabled lane sees it.
  always_comb begin
    w_wdata = wdataM;
    case (w_ones)
      3'd1:    w_wdata = {4{wdataM[7:0]}};
      3'd2:    w_wdata = {2{wdataM[15:0]}};
      default: w_wdata = wdataM;
    endcase
  end

  // The count reaching TIMEOUT means this WAIT cycle is the last one allowed.
  assign w_timeout = (({1'b0, r_wcnt} + 9'd1) == 9'(TIMEOUT));

  // Sequencing FSM, captured request fields, wait counter, load data and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= 8'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= 32'd0;
      r_we    <= 1'b0;
      r_wstrb <= 4'd0;
      r_wdata <= 32'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_addr  <= {addrM[31:2], 2'b00};
            r_we    <= weM;
            r_wstrb <= weM ? ampM : 4'b1111;
            r_wdata <= w_wdata;
            r_valid <= 1'b1;
            r_state <= S_REQ;
          end else if (w_err) begin
            r_err <= 1'b1;
          end
        end
        S_REQ: begin
          if (req_ready) begin
            r_valid <= 1'b0;
            r_wcnt  <= 8'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt + 8'd1;
          if (rsp_valid) begin
            r_rdata <= rsp_rdata;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall is raised combinationally in IDLE so the pipeline freezes in the request cycle.
  assign stallM = ((r_state == S_IDLE) & w_go) | (r_state == S_REQ) | (r_state == S_WAIT);

  assign rdataM    = r_rdata;
  assign errM      = r_err;
  assign req_valid = r_valid;
  assign req_addr  = r_addr;
  assign req_we    = r_we;
  assign req_wstrb = r_wstrb;
  assign req_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus randomized accesses,
// with expectations computed from the access rules (latency, lane replication, timeout).
module tb_dmem_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic        weM;
  logic        reM;
  logic [3:0]  ampM;
  logic [31:0] rdataM;
  logic        stallM;
  logic        errM;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .addrM(addrM), .wdataM(wdataM), .weM(weM), .reM(reM), .ampM(ampM),
    .rdataM(rdataM), .stallM(stallM), .errM(errM),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [3:0] amp);
    int n;
    n = $countones(amp);
    if (n == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  // One complete access; rdly = cycles of req_ready low, rsp_dly = WAIT cycles before rsp_valid.
  task automatic run_access(input logic re, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] amp,
                            input int rdly, input int rsp_dly, input logic [31:0] rdat);
    logic        timed_out;
    int          exp_stall;
    logic [31:0] exp_rd;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
    int vseen = 0;
    int wseen = 0;
    int stall_cnt = 0;
    bit done = 0;
    timed_out = (rsp_dly >= TO);
    exp_stall = 1 + (rdly + 1) + (timed_out ? TO : rsp_dly + 1);
    exp_rd    = timed_out ? 32'd0 : rdat;
    e_addr    = addr & ~32'd3;
    e_strb    = we ? amp : 4'b1111;
    e_wd      = exp_wdata(wd, amp);

    @(negedge clk);
    reM = re; weM = we; addrM = addr; wdataM = wd; ampM = amp;
    #1;
    for (int c = 0; c < 80 && !done; c++) begin
      if (stallM) stall_cnt++;
      if (c > 0 && !stallM) begin
        done = 1;
        chk("done_rdata", rdataM, exp_rd);
        chk("done_err", 32'(errM), 32'(timed_out));
        chk("done_valid", 32'(req_valid), 0);
        req_ready = 0;
        rsp_valid = 1;
        rsp_rdata = $urandom;
      end else begin
        chk("busy_err", 32'(errM), 0);
        if (req_valid) begin
          chk("req_addr", req_addr, e_addr);
          chk("req_we", 32'(req_we), 32'(we));
          chk("req_wstrb", 32'(req_wstrb), 32'(e_strb));
          chk("req_wdata", req_wdata, e_wd);
          chk("rdata_hold", rdataM, m_rdata);
          req_ready = (vseen == rdly);
          vseen++;
          rsp_valid = 1'($urandom_range(0, 1));
          rsp_rdata = $urandom;
        end else if (c > 0) begin
          req_ready = 0;
          rsp_valid = (wseen == rsp_dly);
          rsp_rdata = rdat;
          wseen++;
        end else begin
          req_ready = 0;
          rsp_valid = 0;
        end
        @(negedge clk);
        #1;
      end
    end
    chk("completed", 32'(done), 1);
    chk("stall_cycles", stall_cnt, exp_stall);
    m_rdata = exp_rd;

    // Inputs still asserted through DONE must not start a second access.
    @(negedge clk);
    #1;
    chk("no_reissue", 32'(req_valid), 0);
    chk("post_rdata", rdataM, m_rdata);
    chk("post_err", 32'(errM), 0);
    reM = 0; weM = 0; rsp_valid = 0;
  endtask

  task automatic err_access(input logic re);
    @(negedge clk);
    weM = 1; reM = re; ampM = 4'b0000; addrM = $urandom; wdataM = $urandom;
    #1;
    chk("err_stall", 32'(stallM), 0);
    chk("err_novalid0", 32'(req_valid), 0);
    @(negedge clk);
    #1;
    chk("err_pulse", 32'(errM), 1);
    chk("err_stall1", 32'(stallM), 0);
    chk("err_novalid1", 32'(req_valid), 0);
    weM = 0; reM = 0;
    @(negedge clk);
    #1;
    chk("err_single", 32'(errM), 0);
    chk("err_rdata", rdataM, m_rdata);
  endtask

  initial begin
    logic        r_re;
    logic        r_we;
    logic [3:0]  r_amp;
    reset = 0;
    addrM = 0; wdataM = 0; weM = 0; reM = 0; ampM = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = 0;
    m_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(req_valid), 0);
    chk("rst_we", 32'(req_we), 0);
    chk("rst_wstrb", 32'(req_wstrb), 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_wdata", req_wdata, 0);
    chk("rst_rdata", rdataM, 0);
    chk("rst_err", 32'(errM), 0);
    chk("rst_stall", 32'(stallM), 0);
    @(negedge clk);
    reset = 1;

    run_access(1, 0, 32'h0000_1006, 32'h0, 4'b1111, 0, 0, 32'hDEAD_BEEF);
    run_access(0, 1, 32'h0000_2001, 32'h0000_00A5, 4'b0100, 0, 1, 32'h1234_5678);
    run_access(1, 0, 32'h0000_3008, 32'h0, 4'b1111, 5, 2, 32'h0BAD_F00D);
    run_access(1, 0, 32'h0000_400C, 32'h0, 4'b1111, 0, TO, 32'h5555_AAAA);
    run_access(1, 0, 32'h0000_4010, 32'h0, 4'b1111, 0, 0, 32'h7777_1111);
    run_access(1, 1, 32'h0000_5002, 32'h0000_BEEF, 4'b1100, 1, 3, 32'h0102_0304);
    err_access(0);
    err_access(1);

    for (int i = 0; i < 24; i++) begin
      r_re  = 1'($urandom_range(0, 1));
      r_we  = 1'($urandom_range(0, 1));
      r_amp = 4'($urandom_range(0, 15));
      if (!r_re && !r_we) r_re = 1;
      if (r_we && r_amp == 4'b0000) err_access(r_re);
      else run_access(r_re, r_we, $urandom, $urandom, r_amp,
                      $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom);
    end

    // Reset while an access is in WAIT abandons it; late responses are ignored.
    @(negedge clk);
    reM = 1; weM = 0; addrM = 32'h0000_6000; ampM = 4'b1111; req_ready = 1; rsp_valid = 0;
    @(negedge clk);
    #1;
    chk("rw_req", 32'(req_valid), 1);
    @(negedge clk);
    #1;
    chk("rw_wait_valid", 32'(req_valid), 0);
    chk("rw_wait_stall", 32'(stallM), 1);
    req_ready = 0;
    reset = 0;
    #1;
    chk("rw_rst_valid", 32'(req_valid), 0);
    chk("rw_rst_stall", 32'(stallM), 1);
    chk("rw_rst_rdata", rdataM, 0);
    chk("rw_rst_err", 32'(errM), 0);
    reM = 0;
    #1;
    chk("rw_rst_idle", 32'(stallM), 0);
    @(negedge clk);
    reset = 1;
    rsp_valid = 1;
    rsp_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    #1;
    chk("rw_late_rdata", rdataM, 0);
    chk("rw_late_stall", 32'(stallM), 0);
    chk("rw_late_valid", 32'(req_valid), 0);
    rsp_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end
endmodule
